uart_tx_serializer: RTL

UART transmit framing stage that sits directly downstream of the parity generator.
- Consumes the generator's 8-bit data and parity bit and shifts them onto the serial line.
- Frame order: start bit, 8 data bits LSB-first, optional parity bit, stop bit(s).
- Bit timing comes from an internal clocks-per-bit counter; upstream is told when the line is busy and when a frame has completed.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx_serializer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and line levels.
// Used by both the transmit serializer and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Clocks-per-bit counter; pulses bit_end on the last cycle of each bit.
// clear restarts the count so a new frame starts on a full bit boundary.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit framing: start, 8 data bits LSB-first, optional parity,
// stop bit(s). All outputs come straight from flops.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    input  logic       parity_in,
    input  logic       parity_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t state, state_nx;

    logic [7:0] shift_q, shift_nx;
    logic       par_q, par_nx;
    logic       pen_q, pen_nx;
    logic [2:0] idx_q, idx_nx;
    logic       tx_q, tx_nx;
    logic       busy_q, busy_nx;
    logic       done_q, done_nx;
    logic       timer_clear;
    logic       bit_end;
    logic [2:0] idx_inc;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    assign idx_inc = idx_q + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            shift_q <= shift_nx;
            par_q   <= par_nx;
            pen_q   <= pen_nx;
            idx_q   <= idx_nx;
            tx_q    <= tx_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    // Next-state logic also computes the registered line value for the
    // following cycle, so tx changes exactly on the bit boundary.
    always_comb begin
        state_nx    = state;
        shift_nx    = shift_q;
        par_nx      = par_q;
        pen_nx      = pen_q;
        idx_nx      = idx_q;
        tx_nx       = tx_q;
        busy_nx     = busy_q;
        done_nx     = 1'b0;
        timer_clear = 1'b0;

        unique case (state)
            IDLE: begin
                tx_nx   = UART_IDLE_LEVEL;
                busy_nx = 1'b0;
                if (tx_start) begin
                    shift_nx    = data_in;
                    par_nx      = parity_in;
                    pen_nx      = parity_en;
                    idx_nx      = '0;
                    timer_clear = 1'b1;
                    tx_nx       = UART_START_LEVEL;
                    busy_nx     = 1'b1;
                    state_nx    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_nx   = '0;
                    tx_nx    = shift_q[0];
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        idx_nx = '0;
                        if (pen_q) begin
                            tx_nx    = par_q;
                            state_nx = PARITY;
                        end else begin
                            tx_nx    = UART_STOP_LEVEL;
                            state_nx = STOP;
                        end
                    end else begin
                        idx_nx = idx_inc;
                        tx_nx  = shift_q[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    idx_nx   = '0;
                    tx_nx    = UART_STOP_LEVEL;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_nx   = '0;
                        tx_nx    = UART_IDLE_LEVEL;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        idx_nx = idx_inc;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = UART_IDLE_LEVEL;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
